// File: rtl/bulls_cows_if.sv
// Bulls & Cows responder bus: secret/guess offers, result channel, status.
// master = driver of secrets/guesses, slave = the scorer.
interface bulls_cows_if #(
   parameter int DIGITS  = 4,
   parameter int DIGIT_W = 4,
   parameter int ATT_W   = 4
);
   localparam int CW = $clog2(DIGITS + 1);

   logic                      new_game;
   logic                      secret_valid;
   logic [DIGITS*DIGIT_W-1:0] secret_in;
   logic                      secret_ready;
   logic                      secret_error;
   logic                      guess_valid;
   logic [DIGITS*DIGIT_W-1:0] guess_in;
   logic                      guess_ready;
   logic                      result_valid;
   logic                      result_ready;
   logic [CW-1:0]             bulls;
   logic [CW-1:0]             cows;
   logic                      win;
   logic [ATT_W-1:0]          attempts;
   logic                      game_over;

   modport master (
      output new_game, secret_valid, secret_in,
      output guess_valid, guess_in, result_ready,
      input  secret_ready, secret_error, guess_ready,
      input  result_valid, bulls, cows, win,
      input  attempts, game_over
   );

   modport slave (
      input  new_game, secret_valid, secret_in,
      input  guess_valid, guess_in, result_ready,
      output secret_ready, secret_error, guess_ready,
      output result_valid, bulls, cows, win,
      output attempts, game_over
   );
endinterface

// File: rtl/bulls_cows_scorer.sv
// Bulls & Cows scorer: one guess digit per cycle against a latched secret.
// BC_SECRET_CHECK_EN enables rejection of secrets with digits >9 or repeats.
module bulls_cows_scorer #(
   parameter int DIGITS       = 4,
   parameter int DIGIT_W      = 4,
   parameter int MAX_ATTEMPTS = 10,
   parameter int ATT_W        = 4
) (
   input  logic          clock,
   input  logic          reset_n,
   bulls_cows_if.slave   bus
);
   localparam int CW = $clog2(DIGITS + 1);
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int WW = DIGITS * DIGIT_W;

   typedef enum logic [2:0] {
      S_IDLE, S_ARMED, S_SCORE, S_RESULT, S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [WW-1:0]    sec_q, sec_d;
   logic [WW-1:0]    gs_q, gs_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [CW-1:0]    bull_q, bull_d;
   logic [CW-1:0]    cow_q, cow_d;
   logic [ATT_W-1:0] att_q, att_d;
   logic             rv_q, rv_d;
   logic             err_q, err_d;

   logic               sec_ok;
   logic [DIGIT_W-1:0] g_dig;
   logic               hit_bull;
   logic               hit_cow;
   logic [ATT_W-1:0]   att_inc;
   logic               win_w;

`ifdef BC_SECRET_CHECK_EN
   always_comb begin
      sec_ok = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (bus.secret_in[i*DIGIT_W +: DIGIT_W] > DIGIT_W'(9))
            sec_ok = 1'b0;
         for (int j = i + 1; j < DIGITS; j++)
            if (bus.secret_in[i*DIGIT_W +: DIGIT_W] ==
                bus.secret_in[j*DIGIT_W +: DIGIT_W])
               sec_ok = 1'b0;
      end
   end
`else
   assign sec_ok = 1'b1;
`endif

   // Out-of-range guess digits never match, even against a bad secret.
   always_comb begin
      g_dig    = '0;
      hit_bull = 1'b0;
      hit_cow  = 1'b0;
      for (int i = 0; i < DIGITS; i++)
         if (i == int'(idx_q)) g_dig = gs_q[i*DIGIT_W +: DIGIT_W];
      for (int j = 0; j < DIGITS; j++) begin
         if (g_dig <= DIGIT_W'(9) &&
             sec_q[j*DIGIT_W +: DIGIT_W] == g_dig) begin
            if (j == int'(idx_q)) hit_bull = 1'b1;
            else                  hit_cow  = 1'b1;
         end
      end
   end

   assign att_inc = (att_q == '1) ? att_q : att_q + ATT_W'(1);
   assign win_w   = (bull_q == CW'(DIGITS));

   always_comb begin
      state_d = state_q;
      sec_d   = sec_q;
      gs_d    = gs_q;
      idx_d   = idx_q;
      bull_d  = bull_q;
      cow_d   = cow_q;
      att_d   = att_q;
      rv_d    = rv_q;
      err_d   = 1'b0;
      if (bus.new_game) begin
         state_d = S_IDLE;
         sec_d   = '0;
         gs_d    = '0;
         idx_d   = '0;
         bull_d  = '0;
         cow_d   = '0;
         att_d   = '0;
         rv_d    = 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (bus.secret_valid) begin
                  if (sec_ok) begin
                     sec_d   = bus.secret_in;
                     state_d = S_ARMED;
                  end else begin
                     err_d = 1'b1;
                  end
               end
            end
            S_ARMED: begin
               if (bus.guess_valid) begin
                  gs_d    = bus.guess_in;
                  bull_d  = '0;
                  cow_d   = '0;
                  idx_d   = '0;
                  state_d = S_SCORE;
               end
            end
            S_SCORE: begin
               if (hit_bull)     bull_d = bull_q + CW'(1);
               else if (hit_cow) cow_d  = cow_q + CW'(1);
               if (idx_q == IW'(DIGITS - 1)) state_d = S_RESULT;
               else                          idx_d   = idx_q + IW'(1);
            end
            // One settling cycle before the result is offered.
            S_RESULT: begin
               if (!rv_q) begin
                  rv_d = 1'b1;
               end else if (bus.result_ready) begin
                  rv_d  = 1'b0;
                  att_d = att_inc;
                  if (win_w || att_inc == ATT_W'(MAX_ATTEMPTS))
                     state_d = S_DONE;
                  else
                     state_d = S_ARMED;
               end
            end
            S_DONE: ;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         sec_q   <= '0;
         gs_q    <= '0;
         idx_q   <= '0;
         bull_q  <= '0;
         cow_q   <= '0;
         att_q   <= '0;
         rv_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sec_q   <= sec_d;
         gs_q    <= gs_d;
         idx_q   <= idx_d;
         bull_q  <= bull_d;
         cow_q   <= cow_d;
         att_q   <= att_d;
         rv_q    <= rv_d;
         err_q   <= err_d;
      end
   end

   assign bus.secret_ready = (state_q == S_IDLE);
   assign bus.secret_error = err_q;
   assign bus.guess_ready  = (state_q == S_ARMED);
   assign bus.result_valid = rv_q;
   assign bus.bulls        = bull_q;
   assign bus.cows         = cow_q;
   assign bus.win          = rv_q & win_w;
   assign bus.attempts     = att_q;
   assign bus.game_over    = (state_q == S_DONE);
endmodule

// File: tb/tb_bulls_cows_scorer.sv
// Scoreboard bench for bulls_cows_scorer (MAX_ATTEMPTS=3).
// Stimulus pushes expected results; a negedge monitor pops on handshake.
module tb_bulls_cows_scorer;
   localparam int DIGITS = 4;
   localparam int DW     = 4;
   localparam int AW     = 4;
   localparam int MAXA   = 3;

   logic clock;
   logic reset_n;
   int   errors = 0;
   int   checks = 0;

   typedef struct packed {
      logic [2:0] b;
      logic [2:0] c;
      logic       w;
   } exp_t;
   exp_t sbq[$];

   bulls_cows_if #(.DIGITS(DIGITS), .DIGIT_W(DW), .ATT_W(AW)) bus ();

   bulls_cows_scorer #(
      .DIGITS(DIGITS), .DIGIT_W(DW),
      .MAX_ATTEMPTS(MAXA), .ATT_W(AW)
   ) dut (
      .clock(clock),
      .reset_n(reset_n),
      .bus(bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string nm, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, req);
      end
   endtask

   always @(negedge clock) begin
      if (reset_n && bus.result_valid && bus.result_ready) begin
         if (sbq.size() == 0) begin
            chk("unexpected_result", 1, 0);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            chk("sb_bulls", int'(bus.bulls), int'(e.b));
            chk("sb_cows", int'(bus.cows), int'(e.c));
            chk("sb_win", int'(bus.win), int'(e.w));
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic new_game();
      bus.new_game = 1'b1;
      tick();
      bus.new_game = 1'b0;
      chk("ng_sready", int'(bus.secret_ready), 1);
      chk("ng_att", int'(bus.attempts), 0);
   endtask

   task automatic put_secret(input logic [15:0] s);
      bus.secret_valid = 1'b1;
      bus.secret_in    = s;
      tick();
      bus.secret_valid = 1'b0;
      bus.secret_in    = 16'hFFFF;
   endtask

   task automatic put_guess(input logic [15:0] g);
      int n;
      n = 0;
      while (!bus.guess_ready && n < 20) begin
         tick();
         n++;
      end
      chk("guess_ready_wait", int'(bus.guess_ready), 1);
      bus.guess_valid = 1'b1;
      bus.guess_in    = g;
      tick();
      bus.guess_valid = 1'b0;
      bus.guess_in    = 16'hFFFF;
   endtask

   task automatic run_guess(input logic [15:0] g, input int eb,
                            input int ec, input int att,
                            input int over);
      exp_t e;
      e.b = 3'(eb);
      e.c = 3'(ec);
      e.w = (eb == DIGITS);
      sbq.push_back(e);
      bus.result_ready = 1'b1;
      put_guess(g);
      repeat (DIGITS) tick();
      chk("lat_early", int'(bus.result_valid), 0);
      tick();
      chk("lat_valid", int'(bus.result_valid), 1);
      tick();
      chk("acc_att", int'(bus.attempts), att);
      chk("acc_over", int'(bus.game_over), over);
      chk("acc_gready", int'(bus.guess_ready), 1 - over);
   endtask

   initial begin
      int n;
      bit ok;
      reset_n          = 1'b0;
      bus.new_game     = 1'b0;
      bus.secret_valid = 1'b0;
      bus.secret_in    = '0;
      bus.guess_valid  = 1'b0;
      bus.guess_in     = '0;
      bus.result_ready = 1'b0;
      repeat (3) tick();
      reset_n = 1'b1;
      tick();
      chk("rst_sready", int'(bus.secret_ready), 1);
      chk("rst_gready", int'(bus.guess_ready), 0);
      chk("rst_rvalid", int'(bus.result_valid), 0);
      chk("rst_serr", int'(bus.secret_error), 0);
      chk("rst_att", int'(bus.attempts), 0);
      chk("rst_over", int'(bus.game_over), 0);
      chk("rst_bulls", int'(bus.bulls), 0);

      // Game 1: partial score then win.
      put_secret(16'h1234);
      chk("armed_gready", int'(bus.guess_ready), 1);
      chk("armed_sready", int'(bus.secret_ready), 0);
      run_guess(16'h1243, 2, 2, 1, 0);
      run_guess(16'h1234, 4, 0, 2, 1);
      chk("done_sready", int'(bus.secret_ready), 0);
      chk("done_rvalid", int'(bus.result_valid), 0);
      chk("done_bulls", int'(bus.bulls), 4);
      new_game();

      // Illegal secrets.
`ifdef BC_SECRET_CHECK_EN
      put_secret(16'h1123);
      chk("dup_serr", int'(bus.secret_error), 1);
      chk("dup_sready", int'(bus.secret_ready), 1);
      tick();
      chk("dup_serr_pulse", int'(bus.secret_error), 0);
      put_secret(16'h12A4);
      chk("big_serr", int'(bus.secret_error), 1);
      chk("big_sready", int'(bus.secret_ready), 1);
      tick();
      chk("big_serr_pulse", int'(bus.secret_error), 0);
`else
      put_secret(16'h1123);
      chk("nochk_serr", int'(bus.secret_error), 0);
      chk("nochk_armed", int'(bus.guess_ready), 1);
      new_game();
`endif

      // Backpressure.
      put_secret(16'h9876);
      begin
         exp_t e;
         e.b = 3'd0;
         e.c = 3'd4;
         e.w = 1'b0;
         sbq.push_back(e);
      end
      bus.result_ready = 1'b0;
      put_guess(16'h6789);
      n = 0;
      while (!bus.result_valid && n < 20) begin
         tick();
         n++;
      end
      chk("bp_wait", int'(bus.result_valid), 1);
      ok = 1'b1;
      repeat (7) begin
         tick();
         if (!bus.result_valid || bus.bulls != 0 ||
             bus.cows != 4 || bus.guess_ready)
            ok = 1'b0;
      end
      chk("bp_stable", int'(ok), 1);
      bus.result_ready = 1'b1;
      tick();
      chk("bp_armed", int'(bus.guess_ready), 1);
      chk("bp_att", int'(bus.attempts), 1);
      new_game();

      // Exhaustion, including out-of-range guess digit.
      put_secret(16'h1234);
      run_guess(16'h0000, 0, 0, 1, 0);
      run_guess(16'h4F21, 0, 3, 2, 0);
      run_guess(16'h0000, 0, 0, 3, 1);
      new_game();
      chk("ex_over_clr", int'(bus.game_over), 0);

      // Reset during SCORE: nothing must emerge.
      put_secret(16'h1234);
      bus.result_ready = 1'b1;
      put_guess(16'h1234);
      tick();
      reset_n = 1'b0;
      #1;
      chk("ar_sready", int'(bus.secret_ready), 1);
      chk("ar_rvalid", int'(bus.result_valid), 0);
      tick();
      reset_n = 1'b1;
      ok = 1'b1;
      repeat (10) begin
         tick();
         if (bus.result_valid) ok = 1'b0;
      end
      chk("ar_no_result", int'(ok), 1);
      chk("ar_gready", int'(bus.guess_ready), 0);
      chk("ar_bulls", int'(bus.bulls), 0);
      chk("ar_att", int'(bus.attempts), 0);
      chk("ar_sready2", int'(bus.secret_ready), 1);

      chk("sb_drain", sbq.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
